// File: rtl/trigger_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : trigger_pulse_gen_if
// Description : Config, event and output bundle for trigger_pulse_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface trigger_pulse_gen_if #(
  parameter int pNUM_TRIGGER_PULSES = 8,
  parameter int pNUM_TRIGGER_WIDTH  = 4,
  parameter int pDELAY_WIDTH        = 24,
  parameter int pWIDTH_WIDTH        = 24
);
  logic                                          I_match;
  logic                                          I_trigger_enable;
  logic [pNUM_TRIGGER_WIDTH-1:0]                 I_num_triggers;
  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_delay;
  logic [pWIDTH_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_width;
  logic                                          O_trigger;
  logic                                          O_busy;
  logic [pNUM_TRIGGER_WIDTH-1:0]                 O_pulse_index;
  logic                                          O_done;

  modport master (
    output I_match, I_trigger_enable, I_num_triggers, I_trigger_delay, I_trigger_width,
    input  O_trigger, O_busy, O_pulse_index, O_done
  );

  modport slave (
    input  I_match, I_trigger_enable, I_num_triggers, I_trigger_delay, I_trigger_width,
    output O_trigger, O_busy, O_pulse_index, O_done
  );
endinterface
`default_nettype wire

// File: rtl/trigger_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : trigger_pulse_gen
// Description : Turns one match event into a train of delayed, sized pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_pulse_gen #(
  parameter int pNUM_TRIGGER_PULSES = 8,
  parameter int pNUM_TRIGGER_WIDTH  = 4,
  parameter int pDELAY_WIDTH        = 24,
  parameter int pWIDTH_WIDTH        = 24
) (
  input  wire logic         trigger_clk,
  input  wire logic         reset_n,
  trigger_pulse_gen_if.slave bus
);
  localparam int c_IDX_W = (pNUM_TRIGGER_PULSES > 1) ? $clog2(pNUM_TRIGGER_PULSES) : 1;
  localparam int c_CNT_W = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    WIDTH = 2'd2
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [c_CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic [pNUM_TRIGGER_WIDTH-1:0] r_idx, w_idx_nxt;
  logic [pNUM_TRIGGER_WIDTH-1:0] r_last, w_last_nxt;
  logic                          r_trig, w_trig_nxt;
  logic                          r_done, w_done_nxt;

  logic [pNUM_TRIGGER_WIDTH-1:0] w_idx_inc;
  logic [pNUM_TRIGGER_WIDTH-1:0] w_last_calc;
  logic [pWIDTH_WIDTH-1:0]       w_cur_width;
  logic [c_CNT_W-1:0]            w_width_m1;
  logic [c_CNT_W-1:0]            w_first_delay;
  logic [c_CNT_W-1:0]            w_next_delay;

  logic [pDELAY_WIDTH-1:0] w_delay_tab [pNUM_TRIGGER_PULSES];
  logic [pWIDTH_WIDTH-1:0] w_width_tab [pNUM_TRIGGER_PULSES];

  for (genvar k = 0; k < pNUM_TRIGGER_PULSES; k++) begin : g_entries
    assign w_delay_tab[k] = bus.I_trigger_delay[k*pDELAY_WIDTH +: pDELAY_WIDTH];
    assign w_width_tab[k] = bus.I_trigger_width[k*pWIDTH_WIDTH +: pWIDTH_WIDTH];
  end

  // Index of the last pulse, with the requested count clamped to 1..max
  always_comb begin
    if (bus.I_num_triggers == '0)
      w_last_calc = '0;
    else if (32'(bus.I_num_triggers) > pNUM_TRIGGER_PULSES)
      w_last_calc = pNUM_TRIGGER_WIDTH'(pNUM_TRIGGER_PULSES - 1);
    else
      w_last_calc = bus.I_num_triggers - pNUM_TRIGGER_WIDTH'(1);
  end

  assign w_idx_inc     = r_idx + pNUM_TRIGGER_WIDTH'(1);
  assign w_cur_width   = w_width_tab[r_idx[c_IDX_W-1:0]];
  assign w_width_m1    = (w_cur_width == '0) ? '0 : c_CNT_W'(w_cur_width) - c_CNT_W'(1);
  assign w_first_delay = c_CNT_W'(w_delay_tab[0]);
  assign w_next_delay  = c_CNT_W'(w_delay_tab[w_idx_inc[c_IDX_W-1:0]]);

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_last  <= '0;
      r_trig  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_trig  <= w_trig_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_trig_nxt  = r_trig;
    w_done_nxt  = 1'b0;

    // Dropping the enable mid-sequence abandons it silently, without O_done
    if (r_state != IDLE && !bus.I_trigger_enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_trig_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.I_match && bus.I_trigger_enable) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = w_first_delay;
            w_idx_nxt   = '0;
            w_last_nxt  = w_last_calc;
          end
        end
        DELAY: begin
          if (r_cnt == '0) begin
            w_state_nxt = WIDTH;
            w_trig_nxt  = 1'b1;
            w_cnt_nxt   = w_width_m1;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_W'(1);
          end
        end
        WIDTH: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - c_CNT_W'(1);
          end else begin
            w_trig_nxt = 1'b0;
            if (r_idx == r_last) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = DELAY;
              w_idx_nxt   = w_idx_inc;
              w_cnt_nxt   = w_next_delay;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_trig_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign bus.O_trigger     = r_trig;
  assign bus.O_busy        = (r_state != IDLE);
  assign bus.O_pulse_index = r_idx;
  assign bus.O_done        = r_done;

endmodule
`default_nettype wire

// File: doc/trigger_pulse_gen.md
# trigger_pulse_gen

Downstream consumer of the main register block's trigger settings: converts a single-cycle pattern-match event into a programmable train of up to pNUM_TRIGGER_PULSES output trigger pulses, each with its own delay and width in trigger-clock cycles. It sits between the front-end pattern matcher (event source) and the phase-shiftable trigger output pin. The configuration buses come straight from the register block and are treated as quasi-static.

## Interface
Parameters:
- pNUM_TRIGGER_PULSES, 8, maximum pulses per match event
- pNUM_TRIGGER_WIDTH, 4, width of pulse-count field
- pDELAY_WIDTH, 24, bits per delay entry
- pWIDTH_WIDTH, 24, bits per width entry

Ports:
- trigger_clk  in  1  sole clock (phase-shifted trigger clock)
- reset_n  in  1  asynchronous, active-low reset
- I_match  in  1  single-cycle match event from pattern matcher
- I_trigger_enable  in  1  global enable; low aborts/blocks sequences
- I_num_triggers  in  pNUM_TRIGGER_WIDTH  number of pulses per event
- I_trigger_delay  in  pDELAY_WIDTH*pNUM_TRIGGER_PULSES  entry k at [k*pDELAY_WIDTH +: pDELAY_WIDTH]
- I_trigger_width  in  pWIDTH_WIDTH*pNUM_TRIGGER_PULSES  entry k at [k*pWIDTH_WIDTH +: pWIDTH_WIDTH]
- O_trigger  out  1  registered trigger pulse train
- O_busy  out  1  sequence in progress (state != IDLE)
- O_pulse_index  out  pNUM_TRIGGER_WIDTH  index k of pulse currently delaying/active
- O_done  out  1  single-cycle pulse when last pulse of a sequence ends

## Operation
- States: IDLE, DELAY, WIDTH.
- Effective count N = 1 if I_num_triggers == 0; pNUM_TRIGGER_PULSES if I_num_triggers > pNUM_TRIGGER_PULSES; else I_num_triggers. N latched at sequence start.
- Effective width W_k = 1 if entry is 0, else entry. Delay d_k used as-is (0 legal).
- IDLE: on edge with I_match=1 and I_trigger_enable=1 -> DELAY, counter <= d_0, index <= 0.
- DELAY: counter == 0 -> WIDTH, O_trigger <= 1, counter <= W_k-1; else decrement.
- WIDTH: counter != 0 -> decrement. counter == 0 -> O_trigger <= 0; if index == N-1 -> IDLE, O_done <= 1, index <= 0; else index <= index+1, counter <= d_(index+1), -> DELAY.
- Delay/width entries read live by current index; register block must not change them while O_busy=1 (not sampled beyond this rule).
- I_match while not IDLE: ignored, no queuing (includes match on the edge the final pulse drops).
- I_trigger_enable low on any edge while not IDLE: -> IDLE, O_trigger <= 0, index <= 0, no O_done. Enable low in IDLE: match ignored.
- Reset (any time, incl. mid-pulse): state IDLE, counter 0, O_trigger 0, O_busy 0, O_pulse_index 0, O_done 0; takes effect immediately, asynchronously.

## Timing
- Match sampled at edge T: first rising O_trigger at edge T+1+d_0 (min latency 1 cycle).
- Each pulse high for exactly W_k cycles.
- Between pulse k-1 and k: O_trigger low for exactly d_k+1 cycles (d_k=0 -> 1 low cycle; pulses never merge).
- O_done high for one cycle starting on the same edge the final pulse falls; O_busy falls that same edge.
- O_busy high from edge T+? : asserted from edge T (entry to DELAY).
- Earliest re-trigger: match on edge after O_done edge is accepted.
- Counters are pDELAY_WIDTH/pWIDTH_WIDTH wide; max values (2^24-1) must count fully without wrap.

## Test plan
- Single pulse: N=1, d_0=0, W_0=1, match at edge T -> O_trigger high exactly one cycle after edge T+1, O_done at edge T+2, O_busy T..T+2.
- Train: N=3, d={5,0,10}, W={2,3,1} -> high cycles at offsets 6-7, 9-11, 23 from T; low gaps 1 and 11 cycles; O_pulse_index 0,1,2; one O_done.
- Clamping: I_num_triggers=0 -> 1 pulse; I_num_triggers=15 -> 8 pulses; width entry 0 -> 1-cycle pulse.
- Ignored match: second I_match during DELAY, WIDTH and on final-fall edge -> no extra pulses; match one cycle later starts new sequence.
- Abort: drop I_trigger_enable mid-WIDTH of pulse 1 -> O_trigger low next edge, O_busy low, no O_done; enable low in IDLE + match -> no activity.
- Async reset: assert reset_n=0 mid-pulse between edges -> O_trigger/O_busy low immediately; after release, match with d_0=2 -> rise at T+3.
